// File: rtl/mmio_fifo_regfile.sv
// ---------------------------------------------------------------------------
// mmio_fifo_regfile
//
// MMIO-addressed 64-bit data queue that sits directly behind the CCI-P Rx
// MMIO decode. The host pushes words by writing DATA and pops them by reading
// DATA. A small register window exposes occupancy and sticky error flags.
// Read responses are registered. The AFU top muxes them onto Tx c2 whenever
// addr_hit is high.
//
// Register window (32-bit word addresses, all registers 64-bit):
//   BASE+0 DATA   : write = push, read = pop head (0 when empty)
//   BASE+2 STATUS : read  = {44'b0, underflow, overflow, full, empty, count[15:0]}
//                   write = bit0 clears both stickies, bit1 flushes the FIFO
//   BASE+4 PEEK   : read  = head without popping (0 when empty), writes ignored
//   Other addresses produce no response and have no side effects.
//
// Ports:
//   clk            rising-edge clock for all logic
//   rst            synchronous, active-high reset
//   mmio_wr_valid  MMIO write request this cycle
//   mmio_rd_valid  MMIO read request this cycle (wins over a simultaneous write)
//   mmio_addr      MMIO word address from the request header
//   mmio_tid       transaction ID from the request header
//   mmio_wr_data   64-bit write data
//   rsp_valid      one-cycle read response strobe, one cycle after the request
//   rsp_tid        TID echoed from the answered request
//   rsp_data       read response data
//   addr_hit       registered; high with rsp_valid for responses from this block
//   fifo_count     current occupancy (0..DEPTH)
//   fifo_empty     fifo_count == 0
//   fifo_full      fifo_count == DEPTH
// ---------------------------------------------------------------------------
module mmio_fifo_regfile #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mmio_wr_valid,
  input  logic                     mmio_rd_valid,
  input  logic [15:0]              mmio_addr,
  input  logic [8:0]               mmio_tid,
  input  logic [63:0]              mmio_wr_data,
  output logic                     rsp_valid,
  output logic [8:0]               rsp_tid,
  output logic [63:0]              rsp_data,
  output logic                     addr_hit,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OFS_DATA   = 3'd0;
  localparam logic [2:0] OFS_STATUS = 3'd2;
  localparam logic [2:0] OFS_PEEK   = 3'd4;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic          ovf_q,      ovf_d;
  logic          unf_q,      unf_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [8:0]    rsp_tid_q,   rsp_tid_d;
  logic [63:0]   rsp_data_q,  rsp_data_d;
  logic          addr_hit_q,  addr_hit_d;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic win_hit;
  logic sel_data, sel_status, sel_peek;
  logic rd_req, wr_req;
  logic is_empty, is_full;

  // BASE_ADDR is 8-aligned, so the upper bits select the window and the low
  // three bits select the register inside it.
  assign win_hit    = (mmio_addr[15:3] == BASE_ADDR[15:3]);
  assign sel_data   = win_hit && (mmio_addr[2:0] == OFS_DATA);
  assign sel_status = win_hit && (mmio_addr[2:0] == OFS_STATUS);
  assign sel_peek   = win_hit && (mmio_addr[2:0] == OFS_PEEK);

  assign rd_req = mmio_rd_valid && (sel_data || sel_status || sel_peek);
  // A write that collides with a read is a protocol violation; drop the write.
  assign wr_req = mmio_wr_valid && !mmio_rd_valid;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic push, pop, ovf_set, unf_set, sticky_clr, flush;

  assign push       = wr_req && sel_data && !is_full;
  assign ovf_set    = wr_req && sel_data &&  is_full;
  assign pop        = mmio_rd_valid && sel_data && !is_empty;
  assign unf_set    = mmio_rd_valid && sel_data &&  is_empty;
  assign sticky_clr = wr_req && sel_status && mmio_wr_data[0];
  assign flush      = wr_req && sel_status && mmio_wr_data[1];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // push and pop are mutually exclusive (one is a write, the other a read)
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_q - CW'(1);
    end
    // flush only happens on a STATUS write, which never coincides with push/pop
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Set and clear cannot coincide: set needs a DATA access, clear a STATUS write.
  assign ovf_d = sticky_clr ? 1'b0 : (ovf_q | ovf_set);
  assign unf_d = sticky_clr ? 1'b0 : (unf_q | unf_set);

  // -------------------------------------------------------------------------
  // Read response
  // -------------------------------------------------------------------------
  logic [63:0] head_word;
  logic [63:0] status_word;

  // Head as seen before this cycle's pop; an empty queue reads as zero.
  assign head_word   = is_empty ? 64'h0 : mem[rd_ptr_q];
  assign status_word = {44'h0, unf_q, ovf_q, is_full, is_empty, 16'(count_q)};

  always_comb begin
    rsp_valid_d = rd_req;
    addr_hit_d  = rd_req;
    rsp_tid_d   = rsp_tid_q;
    rsp_data_d  = rsp_data_q;
    if (rd_req) begin
      rsp_tid_d = mmio_tid;
      if (sel_status) begin
        rsp_data_d = status_word;
      end else begin
        rsp_data_d = head_word;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // Storage has no reset so it can map onto RAM; contents after reset are
  // never observable because count restarts at zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= mmio_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
      addr_hit_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
      addr_hit_q  <= addr_hit_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rsp_valid  = rsp_valid_q;
  assign rsp_tid    = rsp_tid_q;
  assign rsp_data   = rsp_data_q;
  assign addr_hit   = addr_hit_q;
  assign fifo_count = count_q;
  assign fifo_empty = is_empty;
  assign fifo_full  = is_full;

endmodule
